// File: rtl/clock_set_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl_pkg
//   Shared definitions for the alarm-clock mode/set sequencer and the counter
//   datapath: board mode codes, sequencer state encoding and the mode decoder.
// ---------------------------------------------------------------------------
package clock_set_ctrl_pkg;

  // Board mode switch codes. Code 3 is reserved and behaves as RUN.
  localparam logic [1:0] MODE_RUN       = 2'd0;
  localparam logic [1:0] MODE_SET_TIME  = 2'd1;
  localparam logic [1:0] MODE_SET_ALARM = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SET_TIME  = 2'd1,
    ST_SET_ALARM = 2'd2
  } state_t;

  function automatic state_t decode_mode(input logic [1:0] mode);
    case (mode)
      MODE_SET_TIME:  return ST_SET_TIME;
      MODE_SET_ALARM: return ST_SET_ALARM;
      default:        return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//   One push-button path: 2-FF synchroniser, debounce counter, debounced
//   level, arm flag and a 1-cycle rising-edge strobe. With AUTO_REPEAT_EN
//   defined, a held button also produces repeat strobes HOLD_CYCLES after the
//   first strobe and then every REPEAT_CYCLES.
// Ports
//   clk     in  system clock
//   clr     in  synchronous active-high reset
//   raw     in  asynchronous raw button
//   disarm  in  1-cycle pulse on a sequencer state change
//   level   out debounced button level
//   strobe  out 1-cycle press (or repeat) strobe
// ---------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
`ifdef AUTO_REPEAT_EN
  ,
  parameter int HOLD_CYCLES     = 100,
  parameter int REPEAT_CYCLES   = 25
`endif
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  input  logic disarm,
  output logic level,
  output logic strobe
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1, sync2;
  logic [DB_W-1:0] db_cnt;
  logic            level_q, level_prev, armed;
  logic            rise;

  // The debounced level comes out of reset high and the arm flag low, so a
  // button held through reset looks like an old press: it stays disarmed
  // until its debounced level has been seen low.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      db_cnt     <= '0;
      level_q    <= 1'b1;
      level_prev <= 1'b1;
      armed      <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      sync1 <= raw;
      sync2 <= sync1;
      // Count consecutive samples that disagree with the accepted level.
      if (sync2 == level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt  <= '0;
        level_q <= sync2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      level_prev <= level_q;
      if (disarm)        armed <= ~level_q;
      else if (!level_q) armed <= 1'b1;
    end
  end

  assign rise  = level_q & ~level_prev;
  assign level = level_q;

`ifdef AUTO_REPEAT_EN
  localparam int RC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RC_W   = $clog2(RC_MAX + 1);
  localparam logic [RC_W-1:0] HOLD_V   = RC_W'(HOLD_CYCLES);
  localparam logic [RC_W-1:0] REPEAT_V = RC_W'(REPEAT_CYCLES);

  logic [RC_W-1:0] rep_cnt;   // cycles since the last strobe
  logic            active;    // first strobe issued for this press
  logic            repeating; // past the initial hold delay

  always_ff @(posedge clk) begin
    if (clr) begin
      strobe    <= 1'b0;
      rep_cnt   <= '0;
      active    <= 1'b0;
      repeating <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (!level_q || !armed || disarm) begin
        rep_cnt   <= '0;
        active    <= 1'b0;
        repeating <= 1'b0;
      end else if (rise) begin
        strobe  <= 1'b1;
        active  <= 1'b1;
        rep_cnt <= RC_W'(1);
      end else if (active && rep_cnt == (repeating ? REPEAT_V : HOLD_V)) begin
        strobe    <= 1'b1;
        repeating <= 1'b1;
        rep_cnt   <= RC_W'(1);
      end else if (active && rep_cnt != {RC_W{1'b1}}) begin
        rep_cnt <= rep_cnt + RC_W'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (clr) strobe <= 1'b0;
    else     strobe <= rise & armed & ~disarm;
  end
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
//   Mode/set sequencer for the alarm clock. Decodes the mode switch into
//   RUN / SET_TIME / SET_ALARM, conditions the two set buttons and routes
//   their strobes to the time or alarm registers. Also drives run gating,
//   seconds clear and the display select/blink mask.
//   Optional feature macro: AUTO_REPEAT_EN (auto-repeat while a button is held).
// Ports
//   clk            in  system clock, rising edge
//   clr            in  synchronous active-high reset
//   tick_1hz       in  1-cycle 1 Hz enable
//   mode[1:0]      in  0=RUN 1=SET_TIME 2=SET_ALARM 3=RUN
//   min_up         in  raw minute button
//   hour_up        in  raw hour button
//   time_min_inc   out increment time minutes strobe
//   time_hr_inc    out increment time hours strobe
//   alarm_min_inc  out increment alarm minutes strobe
//   alarm_hr_inc   out increment alarm hours strobe
//   run_en         out time counters may advance
//   sec_clr        out clear seconds strobe
//   disp_alarm     out display alarm registers
//   disp_on        out display enable (blink mask)
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
`ifdef AUTO_REPEAT_EN
  ,
  parameter int HOLD_CYCLES     = 100,
  parameter int REPEAT_CYCLES   = 25
`endif
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick_1hz,
  input  logic [1:0] mode,
  input  logic       min_up,
  input  logic       hour_up,
  output logic       time_min_inc,
  output logic       time_hr_inc,
  output logic       alarm_min_inc,
  output logic       alarm_hr_inc,
  output logic       run_en,
  output logic       sec_clr,
  output logic       disp_alarm,
  output logic       disp_on
);

  import clock_set_ctrl_pkg::*;

  state_t state_q, state_d;
  logic   state_chg;
  logic   min_level, min_strobe, hr_level, hr_strobe;
  logic   blink_q, sec_clr_q;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
    , .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
  ) u_min_btn (
    .clk    (clk),
    .clr    (clr),
    .raw    (min_up),
    .disarm (state_chg),
    .level  (min_level),
    .strobe (min_strobe)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
    , .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
  ) u_hr_btn (
    .clk    (clk),
    .clr    (clr),
    .raw    (hour_up),
    .disarm (state_chg),
    .level  (hr_level),
    .strobe (hr_strobe)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_RUN;
      sec_clr_q <= 1'b0;
      blink_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      // Registered so the pulse lines up with the first SET_TIME cycle.
      sec_clr_q <= (state_d == ST_SET_TIME) && (state_q != ST_SET_TIME);
      if (state_chg || state_q == ST_RUN || min_level || hr_level) blink_q <= 1'b1;
      else if (tick_1hz)                                           blink_q <= ~blink_q;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    state_d       = decode_mode(mode);
    state_chg     = (state_d != state_q);
    time_min_inc  = 1'b0;
    time_hr_inc   = 1'b0;
    alarm_min_inc = 1'b0;
    alarm_hr_inc  = 1'b0;
    run_en        = 1'b1;
    disp_alarm    = 1'b0;
    case (state_q)
      ST_SET_TIME: begin
        run_en       = 1'b0;
        time_min_inc = min_strobe;
        time_hr_inc  = hr_strobe;
      end
      ST_SET_ALARM: begin
        disp_alarm    = 1'b1;
        alarm_min_inc = min_strobe;
        alarm_hr_inc  = hr_strobe;
      end
      default: ;
    endcase
  end

  assign sec_clr = sec_clr_q;
  // A held button keeps the digits visible while they are being stepped.
  assign disp_on = blink_q | min_level | hr_level;

endmodule
